// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// One shift-add (multiply) or restoring shift-subtract (divide) step per cycle,
// DATA_WIDTH steps per operation, fixed latency regardless of operands.
//
// Ports:
//   clk     - pipeline clock, all state on rising edge
//   reset   - asynchronous active-low reset
//   Start   - request pulse, sampled only while idle
//   Flush   - abort the current operation
//   Funct3  - M-extension operation select
//   SrcA    - multiplicand / dividend (rs1)
//   SrcB    - multiplier / divisor (rs2)
//   Busy    - high whenever an operation is in flight (CALC or DONE)
//   Done    - one-cycle pulse, Result valid; masked by a coincident Flush
//   Result  - operation result, held until the next completed operation
module mul_div_unit #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned OPCODE_LENGTH = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     Start,
    input  logic                     Flush,
    input  logic [OPCODE_LENGTH-1:0] Funct3,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    output logic                     Busy,
    output logic                     Done,
    output logic [DATA_WIDTH-1:0]    Result
);

    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned W2    = 2 * DATA_WIDTH;
    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [OPCODE_LENGTH-1:0] F_MUL    = OPCODE_LENGTH'(0);
    localparam logic [OPCODE_LENGTH-1:0] F_MULH   = OPCODE_LENGTH'(1);
    localparam logic [OPCODE_LENGTH-1:0] F_MULHSU = OPCODE_LENGTH'(2);
    localparam logic [OPCODE_LENGTH-1:0] F_MULHU  = OPCODE_LENGTH'(3);
    localparam logic [OPCODE_LENGTH-1:0] F_DIV    = OPCODE_LENGTH'(4);
    localparam logic [OPCODE_LENGTH-1:0] F_DIVU   = OPCODE_LENGTH'(5);
    localparam logic [OPCODE_LENGTH-1:0] F_REM    = OPCODE_LENGTH'(6);
    localparam logic [OPCODE_LENGTH-1:0] F_REMU   = OPCODE_LENGTH'(7);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [W-1:0]     INT_MIN  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]     ALL_ONES = {W{1'b1}};

    // Registered state
    logic [1:0]               state_q,    state_d;
    logic [OPCODE_LENGTH-1:0] op_q,       op_d;
    logic [W2-1:0]            acc_q,      acc_d;
    logic [W-1:0]             opnd_q,     opnd_d;
    logic [CNT_W-1:0]         cnt_q,      cnt_d;
    logic                     neg_res_q,  neg_res_d;
    logic                     neg_rem_q,  neg_rem_d;
    logic                     div_zero_q, div_zero_d;
    logic                     ovf_q,      ovf_d;
    logic                     busy_q,     busy_d;
    logic                     done_q,     done_d;
    logic [W-1:0]             result_q,   result_d;

    // Start-time operand decode
    logic         in_is_div;
    logic         in_a_signed;
    logic         in_b_signed;
    logic         in_a_neg;
    logic         in_b_neg;
    logic [W-1:0] in_a_mag;
    logic [W-1:0] in_b_mag;

    // Iteration datapath
    logic          op_is_div;
    logic [W:0]    mul_sum;
    logic [W2-1:0] mul_step;
    logic [W:0]    div_shift;
    logic [W:0]    div_diff;
    logic          div_ge;
    logic [W2-1:0] div_step;
    logic [W2-1:0] step;

    // Final result formation
    logic [W2-1:0] prod_signed;
    logic [W-1:0]  quo_signed;
    logic [W-1:0]  rem_signed;
    logic [W-1:0]  final_val;

    // Operation class and operand sign handling for a request on the inputs
    always_comb begin
        in_is_div   = (Funct3 == F_DIV) || (Funct3 == F_DIVU) ||
                      (Funct3 == F_REM) || (Funct3 == F_REMU);
        in_a_signed = (Funct3 == F_MUL) || (Funct3 == F_MULH) || (Funct3 == F_MULHSU) ||
                      (Funct3 == F_DIV) || (Funct3 == F_REM);
        in_b_signed = (Funct3 == F_MUL) || (Funct3 == F_MULH) ||
                      (Funct3 == F_DIV) || (Funct3 == F_REM);
        in_a_neg    = in_a_signed && SrcA[W-1];
        in_b_neg    = in_b_signed && SrcB[W-1];
        // Negating INT_MIN yields INT_MIN, which is the correct unsigned magnitude
        in_a_mag    = in_a_neg ? (W'(0) - SrcA) : SrcA;
        in_b_mag    = in_b_neg ? (W'(0) - SrcB) : SrcB;
    end

    // One step of either algorithm; the accumulator holds {hi, lo} for both.
    // Multiply: hi = partial product, lo = remaining multiplier bits, opnd = multiplicand.
    // Divide:   hi = partial remainder, lo = dividend bits / quotient, opnd = divisor.
    always_comb begin
        op_is_div = (op_q == F_DIV) || (op_q == F_DIVU) ||
                    (op_q == F_REM) || (op_q == F_REMU);

        mul_sum  = {1'b0, acc_q[W2-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
        mul_step = {mul_sum, acc_q[W-1:1]};

        // Remainder stays below the divisor, so the shifted value fits in W+1 bits
        div_shift = {acc_q[W2-1:W], acc_q[W-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ge    = ~div_diff[W];
        div_step  = {(div_ge ? div_diff[W-1:0] : div_shift[W-1:0]), acc_q[W-2:0], div_ge};

        step = op_is_div ? div_step : mul_step;
    end

    // Sign fix-up and special cases applied to the value produced by the last step
    always_comb begin
        prod_signed = neg_res_q ? (W2'(0) - step) : step;
        quo_signed  = neg_res_q ? (W'(0) - step[W-1:0]) : step[W-1:0];
        rem_signed  = neg_rem_q ? (W'(0) - step[W2-1:W]) : step[W2-1:W];

        final_val = '0;
        case (op_q)
            F_MUL:                     final_val = prod_signed[W-1:0];
            F_MULH, F_MULHSU, F_MULHU: final_val = prod_signed[W2-1:W];
            F_DIV, F_DIVU: begin
                if (div_zero_q) begin
                    final_val = ALL_ONES;
                end else if (ovf_q) begin
                    final_val = INT_MIN;
                end else begin
                    final_val = quo_signed;
                end
            end
            F_REM, F_REMU: begin
                // Divide by zero leaves |SrcA| in the remainder; restoring its sign gives SrcA
                if (ovf_q) begin
                    final_val = '0;
                end else begin
                    final_val = rem_signed;
                end
            end
            default: final_val = '0;
        endcase
    end

    // Next-state and datapath control
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        cnt_d      = cnt_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;
        result_d   = result_q;

        case (state_q)
            S_IDLE: begin
                if (Start && !Flush) begin
                    op_d       = Funct3;
                    acc_d      = in_is_div ? {{W{1'b0}}, in_a_mag} : {{W{1'b0}}, in_b_mag};
                    opnd_d     = in_is_div ? in_b_mag : in_a_mag;
                    cnt_d      = '0;
                    neg_res_d  = in_a_neg ^ in_b_neg;
                    neg_rem_d  = in_a_neg;
                    div_zero_d = (SrcB == '0);
                    ovf_d      = (Funct3 == F_DIV || Funct3 == F_REM) &&
                                 (SrcA == INT_MIN) && (SrcB == ALL_ONES);
                    state_d    = S_CALC;
                end
            end
            S_CALC: begin
                if (Flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = step;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        result_d = final_val;
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            cnt_q      <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            cnt_q      <= cnt_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
        end
    end

    assign Busy   = busy_q;
    // A flush arriving during the DONE cycle cancels the completion pulse
    assign Done   = done_q & ~Flush;
    assign Result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus randomized
// operations compared against a 64-bit arithmetic reference model.
module tb_mul_div_unit;

    localparam int unsigned W       = 32;
    localparam int unsigned LATENCY = W + 1;

    logic          clk;
    logic          reset;
    logic          Start;
    logic          Flush;
    logic [2:0]    Funct3;
    logic [W-1:0]  SrcA;
    logic [W-1:0]  SrcB;
    logic          Busy;
    logic          Done;
    logic [W-1:0]  Result;

    int n_checks = 0;
    int n_errors = 0;

    mul_div_unit #(
        .DATA_WIDTH    (W),
        .OPCODE_LENGTH (3)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .Start  (Start),
        .Flush  (Flush),
        .Funct3 (Funct3),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .Busy   (Busy),
        .Done   (Done),
        .Result (Result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Architectural RV32M semantics computed with 64-bit integer arithmetic
    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
        longint     sa, sb, sub;
        logic [63:0] ua, ub, p;
        logic        ovf;
        logic [31:0] r;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        sub = longint'(ub);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        r   = '0;
        case (f)
            3'd0: begin p = sa * sb;  r = p[31:0];  end
            3'd1: begin p = sa * sb;  r = p[63:32]; end
            3'd2: begin p = sa * sub; r = p[63:32]; end
            3'd3: begin p = ua * ub;  r = p[63:32]; end
            3'd4: begin
                if (b == 0)   r = 32'hFFFF_FFFF;
                else if (ovf) r = a;
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else begin p = ua / ub; r = p[31:0]; end
            end
            3'd6: begin
                if (b == 0)   r = a;
                else if (ovf) r = 32'd0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: begin
                if (b == 0) r = a;
                else begin p = ua % ub; r = p[31:0]; end
            end
        endcase
        return r;
    endfunction

    // Issue one operation and check latency, Busy window, Result and the return to idle.
    // Operands are scrambled after the Start cycle to show they are not needed later.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int          done_at;
        int          busy_bad;
        logic [31:0] res_at_done;
        done_at     = -1;
        busy_bad    = 0;
        res_at_done = 32'hx;
        @(negedge clk);
        Start = 1'b1; Funct3 = f; SrcA = a; SrcB = b;
        @(negedge clk);
        Start = 1'b0; Funct3 = 3'($urandom); SrcA = $urandom; SrcB = $urandom;
        for (int k = 1; k <= int'(LATENCY); k++) begin
            if (k > 1) @(negedge clk);
            if (Busy !== 1'b1) busy_bad++;
            if (Done === 1'b1 && done_at < 0) begin
                done_at     = k;
                res_at_done = Result;
            end
        end
        check_eq({tag, " latency"}, 32'(done_at), 32'(LATENCY));
        check_eq({tag, " busy"}, 32'(busy_bad), 32'd0);
        check_eq({tag, " result"}, res_at_done, exp);
        @(negedge clk);
        check_eq({tag, " idle"}, {30'd0, Busy, Done}, 32'd0);
        check_eq({tag, " held"}, Result, exp);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          done_cnt;
        int          done_at;
        logic [31:0] res_seen;
        logic [31:0] prev;
        logic [2:0]  f;
        logic [31:0] a, b;

        reset = 1'b0; Start = 1'b0; Flush = 1'b0;
        Funct3 = '0; SrcA = '0; SrcB = '0;
        #12;
        check_eq("reset outputs", {30'd0, Busy, Done}, 32'd0);
        check_eq("reset result", Result, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Directed cases
        run_op("mul 7*-3",   3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_op("mulh -1*-1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        run_op("mulhsu",     3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhu",      3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("div -20/3",  3'd4, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA);
        run_op("rem -20/3",  3'd6, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE);
        run_op("divu 20/3",  3'd5, 32'd20, 32'd3, 32'd6);
        run_op("remu 20/3",  3'd7, 32'd20, 32'd3, 32'd2);
        run_op("div by 0",   3'd4, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
        run_op("rem by 0",   3'd6, 32'h1234_5678, 32'd0, 32'h1234_5678);
        run_op("div ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);

        // Flush during CALC: idle next cycle, no Done, Result untouched
        prev = Result;
        @(negedge clk);
        Start = 1'b1; Funct3 = 3'd4; SrcA = 32'hFFFF_FF9C; SrcB = 32'd7;
        @(negedge clk);
        Start = 1'b0;
        repeat (9) @(negedge clk);
        Flush = 1'b1;
        @(negedge clk);
        Flush = 1'b0;
        check_eq("flush idle", {31'd0, Busy}, 32'd0);
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (Done === 1'b1) done_cnt++;
        end
        check_eq("flush no done", 32'(done_cnt), 32'd0);
        check_eq("flush result kept", Result, prev);

        // Start and Flush together while idle: Flush wins
        @(negedge clk);
        Start = 1'b1; Flush = 1'b1; Funct3 = 3'd0; SrcA = 32'd3; SrcB = 32'd3;
        @(negedge clk);
        Start = 1'b0; Flush = 1'b0;
        check_eq("start+flush idle", {30'd0, Busy, Done}, 32'd0);

        // Start during CALC is ignored: exactly one Done with the first result
        @(negedge clk);
        Start = 1'b1; Funct3 = 3'd3; SrcA = 32'hFFFF_FFFF; SrcB = 32'hFFFF_FFFF;
        @(negedge clk);
        Start = 1'b0;
        done_cnt = 0; done_at = -1; res_seen = 32'hx;
        for (int k = 1; k <= 80; k++) begin
            if (k > 1) @(negedge clk);
            if (Done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) begin done_at = k; res_seen = Result; end
            end
            if (k == 5) begin Start = 1'b1; Funct3 = 3'd0; SrcA = 32'd1; SrcB = 32'd1; end
            if (k == 6) Start = 1'b0;
        end
        check_eq("ignored start done count", 32'(done_cnt), 32'd1);
        check_eq("ignored start latency", 32'(done_at), 32'(LATENCY));
        check_eq("ignored start result", res_seen, 32'hFFFF_FFFE);

        // Asynchronous reset mid-operation
        @(negedge clk);
        Start = 1'b1; Funct3 = 3'd4; SrcA = 32'd1000; SrcB = 32'd7;
        @(negedge clk);
        Start = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("async reset flags", {30'd0, Busy, Done}, 32'd0);
        check_eq("async reset result", Result, 32'd0);
        done_cnt = 0;
        repeat (2) begin
            @(negedge clk);
            if (Done === 1'b1) done_cnt++;
        end
        reset = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (Done === 1'b1) done_cnt++;
        end
        check_eq("reset no done", 32'(done_cnt), 32'd0);
        run_op("mul 5*6 after reset", 3'd0, 32'd5, 32'd6, 32'd30);

        // Randomized operations against the reference model
        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            run_op($sformatf("rand%0d f%0d %08h,%08h", i, f, a, b), f, a, b, ref_op(f, a, b));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
